led_event_blinker: RTL
======================

# led_event_blinker

Output-side companion to the button synchronizer/debouncer path. It converts single-cycle internal event pulses in the 100 MHz domain into human-visible LED blinks. Each accepted event produces exactly one blink of fixed ON length, followed by a mandatory OFF gap. Events that arrive while a blink is in progress are queued in a saturating pending counter. The block sits between internal logic, such as a debounced button edge or an error strobe, and the LED output buffer.

## Interface
- `ON_CYCLES`, default 25_000_000: LED high time in clk cycles; must be ≥1.
- `OFF_CYCLES`, default 25_000_000: minimum LED low gap after each blink, in clk cycles; must be ≥1.
- `PEND_WIDTH`, default 4: width of the pending-event counter; saturates at 2^PEND_WIDTH−1.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `evt`  in  1  event strobe, one cycle per event; already synchronous to `clk`.
- `led`  out  1  registered LED drive, high during ON.
- `busy`  out  1  high whenever the state is not IDLE.
- `pend`  out  PEND_WIDTH  number of queued events not yet blinked.
- `ovf`  out  1  sticky overflow flag; present only with `LED_EVENT_BLINKER_OVF_EN`.
- `ovf_clr`  in  1  clears `ovf`; present only with `LED_EVENT_BLINKER_OVF_EN`.

## Operation
- FSM states are IDLE, ON and GAP. A single down-counter timer is shared by ON and GAP.
- **IDLE**
  - When `evt`=1: go to ON and load the timer with ON_CYCLES−1. `pend` is unchanged.
- **ON**
  - Timer decrements each cycle.
  - When timer=0: go to GAP and load the timer with OFF_CYCLES−1.
- **GAP**
  - Timer decrements each cycle.
  - When timer=0 and (`pend`>0 or `evt`=1): go to ON and reload ON_CYCLES−1.
  - When timer=0 and neither condition holds: go to IDLE.
- **Pending counter**, whose rules apply outside IDLE:
  - `evt` alone: +1, saturating.
  - Consume at GAP exit with `pend`>0: −1.
  - `evt` together with a consume: `pend` is unchanged and the new event is the one that is queued.
  - `evt` at GAP exit with `pend`=0: served directly; `pend` stays 0.
  - `evt` while `pend` is at max: dropped, and `ovf` sets if that feature is compiled in.
- Outputs:
  - `led` = (state==ON), registered.
  - `busy` = (state≠IDLE), registered.
- Reset (async assert, sync deassert is the caller's responsibility):
  - `led`=0, `busy`=0, `pend`=0, `ovf`=0, state=IDLE, timer=0.
  - Asserting reset mid-blink aborts it immediately and drops the queue.
- Parameter rule: timer width is $clog2(max(ON_CYCLES, OFF_CYCLES)). An elaboration check fails if either cycle count is <1.

## Timing
- Latency: `evt` sampled high in IDLE at cycle N drives `led`=1 from cycle N+1.
- ON occupies exactly ON_CYCLES cycles. GAP occupies exactly OFF_CYCLES cycles.
- Back-to-back blinks:
  - The next ON starts the cycle after the last GAP cycle.
  - No IDLE cycle is inserted when work is pending.
  - Blink period is ON_CYCLES+OFF_CYCLES.
- `pend` updates one cycle after the `evt` edge.
- `ovf` sets one cycle after the dropped event.
- `ovf_clr` and an overflowing event in the same cycle leave `ovf`=1; set wins.

## Configuration
- Macro: `LED_EVENT_BLINKER_OVF_EN`.
- Defined: the `ovf` output and `ovf_clr` input exist, and the sticky flag behaves as described above.
- Undefined: both ports and the flag register are absent. Saturation and drop behaviour of `pend` is unchanged.

## Structure
- Shared package `led_blinker_pkg` holds:
  - the state typedef `blink_state_t` {IDLE, ON, GAP}, 2-bit;
  - the default ON/OFF cycle constants for 100 MHz (500 ms each).
- No sub-module: the FSM, timer and pending counter fit in one module.
- `led` feeds an OBUF in the top level.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3 and PEND_WIDTH=2 unless stated.
- **Single event.** `evt` at cycle 10 → `led`=1 in cycles 11–14; `busy`=1 in cycles 11–17; IDLE at 18; `pend`=0 throughout.
- **Queued events.** 3 `evt` pulses during the first ON → `pend` counts to 3, then 4 blinks total with period 7 and no IDLE between them; `pend` decrements at each GAP exit and ends at 0.
- **Saturation and overflow.** 5 `evt` pulses during ON → `pend` saturates at 3 and `ovf`=1; exactly 4 blinks total; `ovf_clr` pulse afterwards → `ovf`=0.
- **Coincident event at GAP exit.** `evt` on the last GAP cycle with `pend`=0 → ON starts the next cycle and `pend` stays 0. Same case with `pend`=2 → `pend` stays 2.
- **Reset mid-operation.** `rstn` low during ON with `pend`=2 → `led`, `busy` and `pend` read 0 in the same cycle; after release, no blinks occur until a new `evt`.
- **Set/clear collision.** `ovf_clr` and an overflowing `evt` in the same cycle → `ovf` remains 1.

Source files
------------

// File: rtl/led_blinker_pkg.sv
// Shared types and constants for the LED event blinker.
// State encoding plus 500 ms reference cycle counts at 100 MHz.
package led_blinker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } blink_state_t;

    localparam int CLK_HZ        = 100_000_000;
    localparam int ON_CYCLES_500 = 50_000_000;
    localparam int OFF_CYCLES_500 = 50_000_000;

endpackage

// File: rtl/led_event_blinker.sv
// Turns single-cycle event pulses into fixed-length LED blinks with a gap.
// Define LED_EVENT_BLINKER_OVF_EN to add the sticky ovf flag and ovf_clr.
module led_event_blinker
    import led_blinker_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000,
    parameter int PEND_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  evt,
`ifdef LED_EVENT_BLINKER_OVF_EN
    input  logic                  ovf_clr,
    output logic                  ovf,
`endif
    output logic                  led,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pend
);

    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

    if (ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_bad_cfg
        $error("led_event_blinker: ON_CYCLES and OFF_CYCLES must be >= 1");
    end

    blink_state_t          state;
    blink_state_t          state_n;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_n;
    logic [PEND_WIDTH-1:0] pend_n;
    logic                  t_done;
    logic                  gap_exit;
    logic                  consume;
    logic                  drop;

    assign t_done   = (timer == '0);
    assign gap_exit = (state == GAP) && t_done;
    assign consume  = gap_exit && (pend != '0);

    always_comb begin
        state_n = state;
        timer_n = timer;
        unique case (state)
            IDLE: begin
                if (evt) begin
                    state_n = ON;
                    timer_n = ON_LOAD;
                end
            end
            ON: begin
                timer_n = timer - 1'b1;
                if (t_done) begin
                    state_n = GAP;
                    timer_n = OFF_LOAD;
                end
            end
            GAP: begin
                timer_n = timer - 1'b1;
                if (t_done) begin
                    if (consume || evt) begin
                        state_n = ON;
                        timer_n = ON_LOAD;
                    end else begin
                        state_n = IDLE;
                        timer_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    // An event at GAP exit is served directly or swaps with the consumed one.
    always_comb begin
        pend_n = pend;
        drop   = 1'b0;
        if (state != IDLE) begin
            if (consume) begin
                if (!evt) begin
                    pend_n = pend - 1'b1;
                end
            end else if (evt && !gap_exit) begin
                if (pend == PEND_MAX) begin
                    drop = 1'b1;
                end else begin
                    pend_n = pend + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            timer <= '0;
            pend  <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            pend  <= pend_n;
            led   <= (state_n == ON);
            busy  <= (state_n != IDLE);
        end
    end

`ifdef LED_EVENT_BLINKER_OVF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
